// File: rtl/dram_lut_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dram_lut_rd_ctrl
// Description : DRAM LUT read-out sequencer. Issues read commands under an
//               outstanding-request limit, counts returned beats, forwards
//               tagged beats to the LUT datapath and builds a status word.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_lut_rd_ctrl #(
    parameter int ADDR_W        = 24,
    parameter int LEN_W         = 16,
    parameter int ADDR_STEP     = 2,
    parameter int BEATS_PER_REQ = 2,
    parameter int MAX_OUTST     = 8
) (
    input  logic              OPB_Clk,
    input  logic              OPB_Rst,
    input  logic              ctrl_start,
    input  logic              ctrl_abort,
    input  logic              ctrl_loop,
    input  logic [ADDR_W-1:0] ctrl_base_addr,
    input  logic [LEN_W-1:0]  ctrl_num_req,
    output logic              dram_cmd_valid,
    output logic [ADDR_W-1:0] dram_cmd_addr,
    output logic              dram_cmd_rnw,
    input  logic              dram_cmd_ready,
    input  logic              dram_rd_valid,
    output logic              lut_rd_valid,
    output logic [LEN_W-1:0]  lut_rd_index,
    output logic              lut_rd_last,
    output logic [31:0]       status_word
);

    localparam int c_BW = (BEATS_PER_REQ > 1) ? $clog2(BEATS_PER_REQ) : 1;
    localparam int c_OW = 8;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic              r_start_d;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_num_req;
    logic              r_loop;
    logic              r_cmd_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_issued;
    logic [c_OW-1:0]   r_outst;
    logic [c_BW-1:0]   r_req_beat;
    logic [LEN_W-1:0]  r_ret_idx;
    logic              r_done;
    logic              r_aborted;
    logic              r_err_spur;
    logic [11:0]       r_pass_cnt;
    logic [15:0]       r_beat_cnt;
    logic              r_lut_valid;
    logic [LEN_W-1:0]  r_lut_index;
    logic              r_lut_last;
    logic [31:0]       r_status;

    logic              w_start_edge;
    logic              w_accept;
    logic              w_beat;
    logic              w_spur;
    logic              w_req_done;
    logic              w_busy;
    logic [c_OW-1:0]   w_outst_nxt;
    logic [LEN_W-1:0]  w_issued_nxt;

    // Handshake / beat classification and next-value arithmetic
    assign w_start_edge = ctrl_start && !r_start_d &&
                          ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_accept     = r_cmd_valid && dram_cmd_ready;
    assign w_beat       = dram_rd_valid && (r_outst != '0);
    assign w_spur       = dram_rd_valid && (r_outst == '0);
    assign w_req_done   = w_beat && (r_req_beat == c_BW'(BEATS_PER_REQ - 1));
    assign w_outst_nxt  = r_outst + c_OW'(w_accept) - c_OW'(w_req_done);
    assign w_issued_nxt = r_issued + LEN_W'(w_accept);
    assign w_busy       = (r_state == c_ST_ISSUE) || (r_state == c_ST_DRAIN);

    // Sequencer, beat accounting, forwarding and status register
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state     <= c_ST_IDLE;
            r_start_d   <= 1'b0;
            r_base      <= '0;
            r_num_req   <= '0;
            r_loop      <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_addr      <= '0;
            r_issued    <= '0;
            r_outst     <= '0;
            r_req_beat  <= '0;
            r_ret_idx   <= '0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_err_spur  <= 1'b0;
            r_pass_cnt  <= '0;
            r_beat_cnt  <= '0;
            r_lut_valid <= 1'b0;
            r_lut_index <= '0;
            r_lut_last  <= 1'b0;
            r_status    <= '0;
        end else begin
            r_start_d <= ctrl_start;
            r_outst   <= w_outst_nxt;

            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 16'd1;
                r_req_beat <= w_req_done ? '0 : r_req_beat + c_BW'(1);
            end
            if (w_req_done) begin
                r_ret_idx <= r_ret_idx + LEN_W'(1);
            end
            if (w_spur) begin
                r_err_spur <= 1'b1;
            end

            r_lut_valid <= w_beat;
            r_lut_index <= r_ret_idx;
            r_lut_last  <= w_req_done && (r_ret_idx == r_num_req - LEN_W'(1));

            if (w_accept) begin
                r_addr   <= r_addr + ADDR_W'(ADDR_STEP);
                r_issued <= w_issued_nxt;
            end

            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_start_edge) begin
                        r_base     <= ctrl_base_addr;
                        r_num_req  <= ctrl_num_req;
                        r_loop     <= ctrl_loop;
                        r_addr     <= ctrl_base_addr;
                        r_issued   <= '0;
                        r_ret_idx  <= '0;
                        r_req_beat <= '0;
                        r_aborted  <= 1'b0;
                        r_err_spur <= 1'b0;
                        r_pass_cnt <= '0;
                        r_beat_cnt <= '0;
                        if (ctrl_num_req == '0) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_done  <= 1'b0;
                            r_state <= c_ST_ISSUE;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    // A presented command holds until accepted, even under abort
                    if (r_cmd_valid && !dram_cmd_ready) begin
                        r_cmd_valid <= 1'b1;
                    end else if (w_issued_nxt == r_num_req) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= c_ST_DRAIN;
                    end else if (ctrl_abort) begin
                        r_cmd_valid <= 1'b0;
                        r_aborted   <= 1'b1;
                        r_state     <= c_ST_DRAIN;
                    end else begin
                        r_cmd_valid <= (w_outst_nxt < c_OW'(MAX_OUTST));
                    end
                end
                c_ST_DRAIN: begin
                    if (r_outst == '0) begin
                        if (!r_aborted) begin
                            r_pass_cnt <= r_pass_cnt + 12'd1;
                        end
                        if (r_loop && !r_aborted) begin
                            r_addr    <= r_base;
                            r_issued  <= '0;
                            r_ret_idx <= '0;
                            r_state   <= c_ST_ISSUE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            r_status <= {w_busy, r_done, r_err_spur, r_aborted, r_pass_cnt, r_beat_cnt};
        end
    end

    assign dram_cmd_valid = r_cmd_valid;
    assign dram_cmd_addr  = r_addr;
    assign dram_cmd_rnw   = 1'b1;
    assign lut_rd_valid   = r_lut_valid;
    assign lut_rd_index   = r_lut_index;
    assign lut_rd_last    = r_lut_last;
    assign status_word    = r_status;

endmodule
`default_nettype wire

// File: tb/tb_dram_lut_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_lut_rd_ctrl
// Description : Scoreboard bench for dram_lut_rd_ctrl with a randomized DRAM
//               responder and a pass/beat level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_lut_rd_ctrl;

    localparam int P_MAX   = 8;
    localparam int P_BEATS = 2;
    localparam int P_STEP  = 2;

    logic        clk;
    logic        rst;
    logic        ctrl_start;
    logic        ctrl_abort;
    logic        ctrl_loop;
    logic [23:0] ctrl_base_addr;
    logic [15:0] ctrl_num_req;
    logic        dram_cmd_valid;
    logic [23:0] dram_cmd_addr;
    logic        dram_cmd_rnw;
    logic        dram_cmd_ready;
    logic        dram_rd_valid;
    logic        lut_rd_valid;
    logic [15:0] lut_rd_index;
    logic        lut_rd_last;
    logic [31:0] status_word;

    dram_lut_rd_ctrl #(
        .ADDR_W(24), .LEN_W(16), .ADDR_STEP(P_STEP),
        .BEATS_PER_REQ(P_BEATS), .MAX_OUTST(P_MAX)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst(rst),
        .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort), .ctrl_loop(ctrl_loop),
        .ctrl_base_addr(ctrl_base_addr), .ctrl_num_req(ctrl_num_req),
        .dram_cmd_valid(dram_cmd_valid), .dram_cmd_addr(dram_cmd_addr),
        .dram_cmd_rnw(dram_cmd_rnw), .dram_cmd_ready(dram_cmd_ready),
        .dram_rd_valid(dram_rd_valid),
        .lut_rd_valid(lut_rd_valid), .lut_rd_index(lut_rd_index),
        .lut_rd_last(lut_rd_last), .status_word(status_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_addr_q[$];
    logic [16:0] exp_lut_q[$];
    int          due_q[$];

    int cyc       = 0;
    int acc_run   = 0;
    int rd_seen   = 0;
    int beats_run = 0;
    int run_n     = 1;
    int ready_pct = 100;
    int lat_max   = 2;
    int rel_budget = 0;
    int vhigh_cnt = 0;
    bit hold_rd   = 1'b0;
    bit spur_req  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit ab, input int pass, input int beats);
        return {1'b0, 1'b1, 1'b0, ab, 12'(pass), 16'(beats)};
    endfunction

    // DRAM responder: random ready, in-order beats after a random latency
    initial begin
        int k;
        dram_cmd_ready = 1'b0;
        dram_rd_valid  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            dram_cmd_ready = ($urandom_range(99) < ready_pct);
            dram_rd_valid  = 1'b0;
            if (spur_req) begin
                dram_rd_valid = 1'b1;
                spur_req      = 1'b0;
            end else if (due_q.size() > 0 && due_q[0] <= cyc && (!hold_rd || rel_budget > 0)) begin
                void'(due_q.pop_front());
                if (hold_rd) rel_budget--;
                dram_rd_valid = 1'b1;
                k = beats_run % (P_BEATS * run_n);
                exp_lut_q.push_back({(k == P_BEATS * run_n - 1), 16'(k / P_BEATS)});
                beats_run++;
            end
        end
    end

    // Monitor: command handshakes and LUT forwarding against the scoreboard
    initial begin
        logic        pend;
        logic [23:0] pend_addr;
        logic [16:0] e;
        pend = 1'b0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                continue;
            end
            if (dram_cmd_valid) vhigh_cnt++;
            if (pend) begin
                chk("cmd_hold_valid", 32'(dram_cmd_valid), 32'd1);
                chk("cmd_hold_addr", 32'(dram_cmd_addr), 32'(pend_addr));
            end
            pend      = dram_cmd_valid && !dram_cmd_ready;
            pend_addr = dram_cmd_addr;
            if (dram_rd_valid) rd_seen++;
            if (dram_cmd_valid && dram_cmd_ready) begin
                acc_run++;
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected actual_addr=0x%0h required=no command", dram_cmd_addr);
                end else begin
                    chk("cmd_addr", 32'(dram_cmd_addr), 32'(exp_addr_q.pop_front()));
                end
                chk("cmd_rnw", 32'(dram_cmd_rnw), 32'd1);
                chk("outst_bound", 32'((acc_run - rd_seen / P_BEATS) <= P_MAX), 32'd1);
                for (int b = 0; b < P_BEATS; b++)
                    due_q.push_back(cyc + $urandom_range(lat_max, 1));
            end
            if (lut_rd_valid) begin
                if (exp_lut_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lut_unexpected actual_index=%0d required=no beat", lut_rd_index);
                end else begin
                    e = exp_lut_q.pop_front();
                    chk("lut_index", 32'(lut_rd_index), 32'(e[15:0]));
                    chk("lut_last", 32'(lut_rd_last), 32'(e[16]));
                end
            end
        end
    end

    task automatic start_run(input logic [23:0] base, input int n, input bit lp);
        @(posedge clk);
        #1;
        ctrl_base_addr = base;
        ctrl_num_req   = 16'(n);
        ctrl_loop      = lp;
        ctrl_start     = 1'b1;
        acc_run = 0;
        rd_seen = 0;
        beats_run = 0;
        if (n > 0) run_n = n;
        exp_addr_q.delete();
        for (int p = 0; p < (lp ? 40 : 1); p++)
            for (int i = 0; i < n; i++)
                exp_addr_q.push_back(24'(32'(base) + i * P_STEP));
        @(posedge clk);
        #1;
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int t;
        t = 0;
        repeat (3) @(negedge clk);
        while (!(status_word[30] && !status_word[31]) && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (t >= bound) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual_status=0x%0h required=done without busy", status_word);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        logic [23:0] base;
        rst = 1'b1;
        ctrl_start = 1'b0;
        ctrl_abort = 1'b0;
        ctrl_loop = 1'b0;
        ctrl_base_addr = '0;
        ctrl_num_req = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        chk("reset_status", status_word, 32'h0);
        chk("reset_cmd_valid", 32'(dram_cmd_valid), 32'd0);
        chk("reset_rnw", 32'(dram_cmd_rnw), 32'd1);
        chk("reset_lut_valid", 32'(lut_rd_valid), 32'd0);
        chk("reset_lut_last", 32'(lut_rd_last), 32'd0);
        chk("reset_lut_index", 32'(lut_rd_index), 32'd0);

        // spurious beat while idle
        spur_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("spur_status", status_word, 32'h2000_0000);

        // basic pass: base 0x100, 4 requests, ready always, latency 2
        ready_pct = 100;
        lat_max = 2;
        start_run(24'h000100, 4, 1'b0);
        wait_done(500);
        chk("basic_status", status_word, 32'h4001_0008);
        chk("basic_cmds", 32'(acc_run), 32'd4);
        chk("basic_lut_drained", 32'(exp_lut_q.size()), 32'd0);

        // randomized passes, first one wrapping the address space
        for (int r = 0; r < 6; r++) begin
            base = (r == 0) ? 24'hFFFFFC : 24'($urandom);
            n = $urandom_range(12, 1);
            ready_pct = $urandom_range(100, 30);
            lat_max = $urandom_range(5, 1);
            start_run(base, n, 1'b0);
            wait_done(3000);
            chk("rand_status", status_word, exp_status(1'b0, 1, P_BEATS * n));
            chk("rand_cmds", 32'(acc_run), 32'(n));
            chk("rand_lut_drained", 32'(exp_lut_q.size()), 32'd0);
        end

        // outstanding limit with returns withheld
        ready_pct = 100;
        lat_max = 1;
        hold_rd = 1'b1;
        rel_budget = 0;
        start_run(24'h002000, 20, 1'b0);
        repeat (40) @(negedge clk);
        chk("outst_cmds_at_limit", 32'(acc_run), 32'(P_MAX));
        chk("outst_valid_low", 32'(dram_cmd_valid), 32'd0);
        rel_budget = 2;
        repeat (20) @(negedge clk);
        chk("outst_cmds_after_release", 32'(acc_run), 32'(P_MAX + 1));
        hold_rd = 1'b0;
        wait_done(3000);
        chk("outst_status", status_word, exp_status(1'b0, 1, 40));

        // zero-length run
        vhigh_cnt = 0;
        start_run(24'h000055, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("zero_status", status_word, 32'h4000_0000);
        repeat (10) @(negedge clk);
        chk("zero_no_valid", 32'(vhigh_cnt), 32'd0);

        // looping run, then abort
        ready_pct = 100;
        lat_max = 2;
        start_run(24'h000300, 2, 1'b1);
        t = 0;
        while (acc_run < 7 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL loop_timeout actual_cmds=%0d required=7", acc_run);
        end
        @(posedge clk);
        #1 ctrl_abort = 1'b1;
        wait_done(1000);
        chk("loop_abort_status", status_word, exp_status(1'b1, acc_run / 2, P_BEATS * acc_run));
        chk("loop_lut_drained", 32'(exp_lut_q.size()), 32'd0);
        exp_addr_q.delete();
        vhigh_cnt = 0;
        repeat (20) @(negedge clk);
        chk("abort_no_valid", 32'(vhigh_cnt), 32'd0);
        ctrl_abort = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
